uart_rx_controller: RTL and testbench

//  UART receiver: the far end of the UART TX path. Oversamples the async serial line, frames

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx_controller.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-line and byte-delivery signals of the UART receiver.
// master: line driver and byte consumer; slave: the receiver itself.
interface uart_rx_if;
    logic       rx_serial;
    logic [1:0] parity_sel;
    logic       rx_ready;
    logic       clear_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output rx_serial, parity_sel, rx_ready, clear_err,
        input  rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy
    );

    modport slave (
        input  rx_serial, parity_sel, rx_ready, clear_err,
        output rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy
    );
endinterface

// File: rtl/uart_rx_controller.sv
// Oversampling UART receiver: start/8 data LSB-first/optional parity/stop, valid/ready byte output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each mid-bit sample.
module uart_rx_controller #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W  = 12;
    localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned MID    = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned START_AT = MID + 1;
`else
    localparam int unsigned START_AT = MID;
`endif
    localparam int unsigned BIT_AT = OVERSAMPLE - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic               rx_meta_q, rx_sync_q;
    logic               armed_q, armed_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         psel_q, psel_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    logic               tick_c;
    logic               at_point_c;
    logic               bit_c;

    function automatic logic exp_parity(input logic [1:0] sel, input logic [7:0] d);
        case (sel)
            2'b01:   return ^d;
            2'b10:   return ~^d;
            default: return 1'b1;
        endcase
    endfunction

    assign tick_c     = (div_cnt_q == DIV_W'(DIV - 1));
    assign at_point_c = tick_c &&
                        (samp_cnt_q == ((state_q == S_START) ? CNT_W'(START_AT) : CNT_W'(BIT_AT)));

`ifdef UART_RX_MAJORITY_EN
    // Two previous tick samples; the decision tick supplies the third vote.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      hist_q <= 2'b11;
        else if (tick_c) hist_q <= {hist_q[0], rx_sync_q};
    end

    assign bit_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync_q) | (hist_q[0] & rx_sync_q);
`else
    assign bit_c = rx_sync_q;
`endif

    // Frame sequencing, sample timing and output register next-state.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        div_cnt_d    = tick_c ? '0 : div_cnt_q + DIV_W'(1);
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        psel_d       = psel_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        if (tick_c) samp_cnt_d = at_point_c ? '0 : samp_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                div_cnt_d  = '0;
                samp_cnt_d = '0;
                if (rx_sync_q) armed_d = 1'b1;
                if (armed_q && !rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (at_point_c) begin
                    if (bit_c) begin
                        state_d = S_IDLE;
                    end else begin
                        psel_d    = bus.parity_sel;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (at_point_c) begin
                    shift_d = {bit_c, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = (psel_q != 2'b00) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_point_c) begin
                    perr_d  = (bit_c != exp_parity(psel_q, shift_q));
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_point_c) begin
                    ferr_d  = !bit_c;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (!bit_c) armed_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        // A completed byte replaces the held one only if the slot is free or being emptied.
        if (done_q && (!rx_valid_q || bus.rx_ready)) begin
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q;
            rx_valid_d   = 1'b1;
        end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d   = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
        end

        if (done_q && rx_valid_q && !bus.rx_ready) overrun_d = 1'b1;
        else if (bus.clear_err)                    overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            armed_q      <= 1'b0;
            div_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            psel_q       <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= bus.rx_serial;
            rx_sync_q    <= rx_meta_q;
            armed_q      <= armed_d;
            div_cnt_q    <= div_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            psel_q       <= psel_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at 16 clocks per bit (DIV=1).
module tb_uart_rx_controller;

    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_rx_if bus ();

    uart_rx_controller #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All bench activity sits 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_serial = b;
        step(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic consume(input string tag);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        check(tag, 32'(bus.rx_valid), 32'd0);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int i = 0;
        while (bus.rx_busy !== lvl && i < 400) begin
            step(1);
            i++;
        end
        check(tag, 32'(bus.rx_busy), 32'(lvl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset          = 1'b0;
        bus.rx_serial  = 1'b1;
        bus.parity_sel = 2'b00;
        bus.rx_ready   = 1'b0;
        bus.clear_err  = 1'b0;
        step(3);
        check("reset_outputs", {bus.rx_data, bus.rx_valid, bus.parity_err,
                                bus.frame_err, bus.overrun, bus.rx_busy}, 32'd0);
        reset = 1'b1;
        step(2);

        // 8N1 byte, with valid rising exactly one clock after the stop sample
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                wait_busy(1'b1, "t1_busy_rise");
                wait_busy(1'b0, "t1_busy_fall");
                check("t1_valid_at_stop", 32'(bus.rx_valid), 32'd0);
                step(1);
                check("t1_valid_next", 32'(bus.rx_valid), 32'd1);
            end
        join
        check("t1_data", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'hA5, 3'b100});
        consume("t1_consume");

        // parity: even good, even bad, odd good, mark bad
        bus.parity_sel = 2'b01;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        check("t2_even_ok", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'h3C, 3'b100});
        consume("t2_consume0");
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check("t2_even_bad", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'h3C, 3'b110});
        consume("t2_consume1");
        check("t2_perr_cleared", 32'(bus.parity_err), 32'd0);
        bus.parity_sel = 2'b10;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check("t2_odd_ok", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'h3C, 3'b100});
        consume("t2_consume2");
        bus.parity_sel = 2'b11;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        check("t2_mark_bad", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'h81, 3'b110});
        consume("t2_consume3");
        bus.parity_sel = 2'b00;

        // short low glitch on an idle line is rejected at the start check
        bus.rx_serial = 1'b1;
        step(BIT_CLKS);
        bus.rx_serial = 1'b0;
        step(4);
        bus.rx_serial = 1'b1;
        check("t3_busy_in_start", 32'(bus.rx_busy), 32'd1);
        step(20);
        check("t3_rejected", {bus.rx_busy, bus.rx_valid}, 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // one-clock high spike at the middle of bit0 is outvoted
        drive_bit(1'b1);
        drive_bit(1'b0);
        bus.rx_serial = 1'b0;
        step(8);
        bus.rx_serial = 1'b1;
        step(1);
        bus.rx_serial = 1'b0;
        step(7);
        for (int i = 1; i < 8; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        check("t3_majority", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'h00, 3'b100});
        consume("t3_consume");
`endif

        // framing error, then a stuck-low line must not retrigger
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("t4_frame_err", {bus.rx_data, bus.rx_valid, bus.frame_err}, {8'h55, 2'b11});
        consume("t4_consume0");
        seen = 0;
        repeat (40 * BIT_CLKS) begin
            step(1);
            if (bus.rx_busy || bus.rx_valid) seen++;
        end
        check("t4_break_quiet", 32'(seen), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("t4_recover", {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err}, {8'h5A, 3'b100});
        consume("t4_consume1");

        // overrun: second byte dropped, flag sticky until clear_err
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check("t5_overrun", {bus.rx_data, bus.rx_valid, bus.overrun}, {8'h11, 2'b11});
        consume("t5_consume");
        check("t5_ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clear_err = 1'b1;
        step(1);
        bus.clear_err = 1'b0;
        check("t5_ovr_clear", 32'(bus.overrun), 32'd0);

        // reset in the middle of data bit 4 abandons the frame
        drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.rx_serial = 1'b0;
        step(8);
        check("t6_busy_before", 32'(bus.rx_busy), 32'd1);
        reset = 1'b0;
        step(1);
        check("t6_reset_outputs", {bus.rx_data, bus.rx_valid, bus.parity_err,
                                   bus.frame_err, bus.overrun, bus.rx_busy}, 32'd0);
        bus.rx_serial = 1'b1;
        step(4);
        reset = 1'b1;
        step(2);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        check("t6_after_reset", {bus.rx_data, bus.rx_valid, bus.parity_err,
                                 bus.frame_err, bus.overrun}, {8'h7E, 4'b1000});
        consume("t6_consume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
